lut_interp_activation_pipe: RTL and testbench
=============================================

LUT_INTERP_ACTIVATION_PIPE -- requirements
Module: lut_interp_activation_pipe

Interface
REQ-001 SHALL have parameter DATA_W, default 8: signed two's-complement width of z_value, LUT entries and a.
REQ-002 SHALL have parameter ADDR_W, default 4: LUT index width; LUT depth 2^ADDR_W; FRAC_W = DATA_W-ADDR_W (>=1).
REQ-003 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  z_value valid.
REQ-006 SHALL have port in_ready  output  1  block accepts z_value this cycle.
REQ-007 SHALL have port z_value  input  DATA_W  signed pre-activation value.
REQ-008 SHALL have port out_valid  output  1  a valid.
REQ-009 SHALL have port out_ready  input  1  consumer accepts a.
REQ-010 SHALL have port a  output  DATA_W  signed interpolated activation.
REQ-011 SHALL have port lut_we  input  1  LUT write strobe.
REQ-012 SHALL have port lut_waddr  input  ADDR_W  LUT write index.
REQ-013 SHALL have port lut_wdata  input  DATA_W  signed LUT write data.

Function
REQ-014 SHALL split z_value: address = z_value[DATA_W-1:FRAC_W], remaining = z_value[FRAC_W-1:0], zero-extended, unsigned.
REQ-015 SHALL read base = LUT[address]; next = LUT[(address+1) mod 2^ADDR_W], except address = 2^(ADDR_W-1)-1 (max positive segment) where next = base (no wrap to most-negative entry).
REQ-016 SHALL compute diff = next-base in DATA_W+1 signed bits, product = diff*remaining exact, shifted = product >>> FRAC_W (arithmetic, floor), a = base+shifted truncated to DATA_W (result lies between base and next, truncation exact).
REQ-017 SHALL be a 3-stage pipeline: S1 registers base/next/remaining, S2 registers diff*remaining, S3 registers a; latency 3 cycles from accepted input to out_valid when unstalled.
REQ-018 SHALL sustain one result per cycle while out_ready stays high.
REQ-019 SHALL use global advance enable en = !out_valid || out_ready; in_ready = en; all stages shift only when en.
REQ-020 SHALL accept a transfer when in_valid && in_ready; SHALL complete output when out_valid && out_ready; a and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-021 SHALL insert bubbles (stage valid low) when en high and in_valid low; bubbles never raise out_valid.
REQ-022 SHALL write LUT[lut_waddr] = lut_wdata on clock edge with lut_we, regardless of en; S1 read in same cycle sees old contents.
REQ-023 SHALL not reorder, drop or duplicate results under any stall pattern.

Reset
REQ-024 SHALL on rst clear all stage valid bits, a = 0, out_valid = 0, all LUT entries = 0, effective next edge.
REQ-025 SHALL discard in-flight data on rst mid-operation; in_ready = 1 the cycle after rst deasserts.
REQ-026 SHALL ignore lut_we and in_valid in cycles where rst is high.

Structure
REQ-027 SHALL place DATA_W/ADDR_W defaults and FRAC_W derivation in the shared activation package.
REQ-028 SHALL instantiate one sub-module act_lut_ram (write port + dual combinational read of base/next with segment clamp); interpolation arithmetic stays in the top.

Verification (DATA_W=8, ADDR_W=4)
REQ-029 SHALL check: LUT[2]=20, LUT[3]=36, z=0x28 -> a=28 three cycles later.
REQ-030 SHALL check: LUT[7]=100, LUT[8]=-100, z=0x7F -> a=100 (segment clamp).
REQ-031 SHALL check: LUT[15]=-8, LUT[0]=0, z=0xF8 -> a=-4 (15->0 wrap); LUT[4]=10, LUT[5]=9, z=0x41 -> a=9 (floor).
REQ-032 SHALL check: 4 back-to-back inputs, out_ready low 5 cycles -> in_ready low once pipeline full, a held stable, all 4 results delivered in order after release.
REQ-033 SHALL check: rst pulsed with 3 results in flight -> out_valid 0 next cycle, no stale outputs, subsequent lookups return 0 until LUT reloaded.
REQ-034 SHALL check: lut_we to index 2 same cycle as z=0x20 accepted -> old LUT[2] used; next z=0x20 uses new value.

Source files
------------

// File: rtl/lut_interp_activation_pipe_pkg.sv
// Shared activation package: default widths for the LUT-interpolated
// activation pipeline and the derivation of the fractional width.
//   DATA_W_DEFAULT : signed width of z_value, LUT entries and the result
//   ADDR_W_DEFAULT : LUT index width (LUT depth is 2**ADDR_W)
//   frac_w_of()    : number of low z_value bits used as interpolation weight
package lut_interp_activation_pipe_pkg;

   localparam int DATA_W_DEFAULT = 8;
   localparam int ADDR_W_DEFAULT = 4;

   // The upper ADDR_W bits of z_value select a segment, the remaining
   // low bits are the position inside that segment.
   function automatic int frac_w_of(input int data_w, input int addr_w);
      return data_w - addr_w;
   endfunction

endpackage

// File: rtl/act_lut_ram.sv
// Activation LUT storage with one write port and two combinational read
// ports returning the segment base and the following entry.
//   clk, rst        : clock and synchronous active-high reset (clears all entries)
//   we/waddr/wdata  : write strobe, index and data (ignored while rst is high)
//   raddr           : segment index being interpolated
//   rd_base         : LUT[raddr]
//   rd_next         : LUT[raddr+1], or LUT[raddr] for the top positive segment
module act_lut_ram
   import lut_interp_activation_pipe_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT,
   parameter int ADDR_W = ADDR_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rd_base,
   output logic [DATA_W-1:0] rd_next
);

   localparam int DEPTH = 1 << ADDR_W;
   // Index of the most positive segment; the index is the signed top of
   // z_value, so incrementing past it would land on the most negative entry.
   localparam logic [ADDR_W-1:0] MAX_POS_SEG = {1'b0, {(ADDR_W-1){1'b1}}};

   logic [DATA_W-1:0] mem_reg [DEPTH];
   logic [ADDR_W-1:0] raddr_inc;

   // Entries are individually resettable, so storage is a register array.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_reg[i] <= '0;
         end
      end else if (we) begin
         mem_reg[waddr] <= wdata;
      end
   end

   // Reads are combinational against pre-edge contents, so a write landing
   // on the same edge as a lookup is not visible to that lookup.
   assign raddr_inc = raddr + ADDR_W'(1);
   assign rd_base   = mem_reg[raddr];
   assign rd_next   = (raddr == MAX_POS_SEG) ? mem_reg[raddr] : mem_reg[raddr_inc];

endmodule

// File: rtl/lut_interp_activation_pipe.sv
// Piecewise-linear activation: z_value selects a LUT segment with its top
// bits and interpolates between that entry and the next with its low bits.
// Three-stage valid/ready pipeline with a single global advance enable.
//   clk, rst                   : clock, synchronous active-high reset
//   in_valid/in_ready/z_value  : input handshake and signed pre-activation
//   out_valid/out_ready/a      : output handshake and signed activation
//   lut_we/lut_waddr/lut_wdata : LUT write port, independent of the pipeline
module lut_interp_activation_pipe
   import lut_interp_activation_pipe_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEFAULT,
   parameter int ADDR_W = ADDR_W_DEFAULT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [DATA_W-1:0] z_value,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic signed [DATA_W-1:0] a,
   input  logic                     lut_we,
   input  logic [ADDR_W-1:0]        lut_waddr,
   input  logic signed [DATA_W-1:0] lut_wdata
);

   localparam int FRAC_W = frac_w_of(DATA_W, ADDR_W);
   // diff is DATA_W+1 signed, the weight FRAC_W+1 signed: product fits exactly.
   localparam int PROD_W = DATA_W + FRAC_W + 2;

   logic                     en;

   logic signed [DATA_W-1:0] lut_base;
   logic signed [DATA_W-1:0] lut_next;

   logic                     s1_valid_reg;
   logic signed [DATA_W-1:0] s1_base_reg;
   logic signed [DATA_W-1:0] s1_next_reg;
   logic [FRAC_W-1:0]        s1_rem_reg;

   logic signed [DATA_W:0]   diff_next;
   logic signed [FRAC_W:0]   rem_ext;
   logic signed [PROD_W-1:0] prod_next;

   logic                     s2_valid_reg;
   logic signed [DATA_W-1:0] s2_base_reg;
   logic signed [PROD_W-1:0] s2_prod_reg;

   logic signed [DATA_W-1:0] a_next;
   logic signed [DATA_W-1:0] a_reg;
   logic                     out_valid_reg;
   logic                     prod_unused;

   // The whole pipe moves together; it only freezes while a result sits
   // at the output unaccepted.
   assign en       = !out_valid_reg || out_ready;
   assign in_ready = en;

   act_lut_ram #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_lut (
      .clk     (clk),
      .rst     (rst),
      .we      (lut_we),
      .waddr   (lut_waddr),
      .wdata   (lut_wdata),
      .raddr   (z_value[DATA_W-1:FRAC_W]),
      .rd_base (lut_base),
      .rd_next (lut_next)
   );

   // Extra sign bit so next-base cannot overflow.
   assign diff_next = {s1_next_reg[DATA_W-1], s1_next_reg} - {s1_base_reg[DATA_W-1], s1_base_reg};
   // Weight is an unsigned fraction; the leading zero keeps it non-negative.
   assign rem_ext   = {1'b0, s1_rem_reg};
   assign prod_next = PROD_W'(diff_next) * PROD_W'(rem_ext);

   // Arithmetic shift right by FRAC_W (floor) then truncation to DATA_W is
   // just this bit window of the product; the sum lies between base and next,
   // so wrapping addition is exact.
   assign a_next = s2_base_reg + s2_prod_reg[FRAC_W +: DATA_W];

   // Discarded product bits: below the binary point and above the result.
   assign prod_unused = ^{s2_prod_reg[PROD_W-1:FRAC_W+DATA_W], s2_prod_reg[FRAC_W-1:0]};

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_reg  <= 1'b0;
         s1_base_reg   <= '0;
         s1_next_reg   <= '0;
         s1_rem_reg    <= '0;
         s2_valid_reg  <= 1'b0;
         s2_base_reg   <= '0;
         s2_prod_reg   <= '0;
         out_valid_reg <= 1'b0;
         a_reg         <= '0;
      end else if (en) begin
         s1_valid_reg  <= in_valid;
         s1_base_reg   <= lut_base;
         s1_next_reg   <= lut_next;
         s1_rem_reg    <= z_value[FRAC_W-1:0];
         s2_valid_reg  <= s1_valid_reg;
         s2_base_reg   <= s1_base_reg;
         s2_prod_reg   <= prod_next;
         out_valid_reg <= s2_valid_reg;
         a_reg         <= a_next;
      end
   end

   assign out_valid = out_valid_reg;
   assign a         = a_reg;

endmodule

// File: tb/tb_lut_interp_activation_pipe.sv
module tb_lut_interp_activation_pipe;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic signed [7:0] z_value = '0;
   logic              out_valid;
   logic              out_ready = 1'b1;
   logic signed [7:0] a;
   logic              lut_we = 1'b0;
   logic [3:0]        lut_waddr = '0;
   logic signed [7:0] lut_wdata = '0;

   int errors = 0;
   int checks = 0;
   int exp_q[$];
   int lut_m[16];
   bit dir_valid = 1'b0;
   int dir_val = 0;
   bit rand_ready = 1'b0;
   int n_out = 0;

   always #5 clk = ~clk;

   lut_interp_activation_pipe #(
      .DATA_W (8),
      .ADDR_W (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .z_value   (z_value),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .a         (a),
      .lut_we    (lut_we),
      .lut_waddr (lut_waddr),
      .lut_wdata (lut_wdata)
   );

   // Reference: linear interpolation with floor, written as plain integers.
   function automatic int floor_div16(input int p);
      if (p >= 0) return p / 16;
      return -((-p + 15) / 16);
   endfunction

   function automatic int model_a(input logic [7:0] z);
      int seg, rem, base, nxt;
      seg  = int'(z) / 16;
      rem  = int'(z) % 16;
      base = lut_m[seg];
      nxt  = (seg == 7) ? base : lut_m[(seg + 1) % 16];
      return base + floor_div16((nxt - base) * rem);
   endfunction

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   // Stimulus side of the scoreboard: record expectation at each accepted input.
   always @(negedge clk) begin
      if (rst) begin
         exp_q.delete();
         for (int i = 0; i < 16; i++) lut_m[i] = 0;
      end else begin
         if (in_valid && in_ready)
            exp_q.push_back(dir_valid ? dir_val : model_a(z_value));
         if (lut_we)
            lut_m[lut_waddr] = int'(lut_wdata);
      end
   end

   // Monitor: compare each completed output transfer, check stall stability.
   logic              prev_hold = 1'b0;
   logic signed [7:0] prev_a = '0;
   always @(negedge clk) begin
      int e;
      if (!rst) begin
         if (prev_hold) begin
            checks++;
            if (!out_valid || a !== prev_a) begin
               errors++;
               $display("FAIL hold: out_valid=%0b a=%0d, required out_valid=1 a=%0d",
                        out_valid, a, prev_a);
            end
         end
         if (out_valid && out_ready) begin
            checks++;
            n_out++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_output: got a=%0d, required no output", a);
            end else begin
               e = exp_q.pop_front();
               if (int'(a) != e) begin
                  errors++;
                  $display("FAIL result #%0d: got a=%0d, required %0d", n_out, a, e);
               end else begin
                  $display("out #%0d a=%0d ok", n_out, a);
               end
            end
         end
         prev_hold = out_valid && !out_ready;
         prev_a    = a;
      end else begin
         prev_hold = 1'b0;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic lut_write(input logic [3:0] idx, input logic [7:0] val);
      lut_we    = 1'b1;
      lut_waddr = idx;
      lut_wdata = val;
      step();
      lut_we    = 1'b0;
   endtask

   task automatic send(input logic [7:0] z, input bit has_exp, input int exp_v,
                       input bit wr = 1'b0, input logic [3:0] wa = '0,
                       input logic [7:0] wd = '0);
      bit acc;
      int guard;
      guard     = 0;
      acc       = 1'b0;
      z_value   = z;
      in_valid  = 1'b1;
      dir_valid = has_exp;
      dir_val   = exp_v;
      lut_we    = wr;
      lut_waddr = wa;
      lut_wdata = wd;
      do begin
         @(negedge clk);
         acc = in_ready;
         step();
         lut_we = 1'b0;
         guard++;
      end while (!acc && guard < 200);
      in_valid  = 1'b0;
      dir_valid = 1'b0;
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout: z=%0h not accepted, required acceptance", z);
      end
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (exp_q.size() != 0 && g < 100) begin
         step();
         g++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] zs[4];
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      @(negedge clk);
      chk("reset_out_valid", int'(out_valid), 0);
      chk("reset_in_ready", int'(in_ready), 1);
      chk("reset_a", int'(a), 0);
      step();

      // Directed interpolation points
      lut_write(4'd2, 8'd20);
      lut_write(4'd3, 8'd36);
      send(8'h28, 1'b1, 28);
      lut_write(4'd7, 8'd100);
      lut_write(4'd8, 8'($signed(-100)));
      send(8'h7F, 1'b1, 100);
      lut_write(4'd15, 8'($signed(-8)));
      lut_write(4'd0, 8'd0);
      send(8'hF8, 1'b1, -4);
      lut_write(4'd4, 8'd10);
      lut_write(4'd5, 8'd9);
      send(8'h41, 1'b1, 9);

      // Write to LUT[2] on the same edge that accepts a lookup of segment 2
      send(8'h20, 1'b1, 20, 1'b1, 4'd2, 8'd50);
      send(8'h20, 1'b1, 50);
      drain();

      // Fill the pipe with the output stalled, hold a 4th input for 5 cycles
      for (int i = 0; i < 4; i++) zs[i] = 8'($urandom_range(0, 255));
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(zs[i], 1'b0, 0);
      z_value  = zs[3];
      in_valid = 1'b1;
      repeat (5) begin
         @(negedge clk);
         chk("stall_in_ready", int'(in_ready), 0);
         step();
      end
      out_ready = 1'b1;
      send(zs[3], 1'b0, 0);
      drain();

      // Random LUT contents and random traffic with random back-pressure
      rand_ready = 1'b1;
      for (int i = 0; i < 16; i++) lut_write(4'(i), 8'($urandom_range(0, 255)));
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 2)) step();
         if ($urandom_range(0, 7) == 0)
            send(8'($urandom_range(0, 255)), 1'b0, 0, 1'b1,
                 4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
         else
            send(8'($urandom_range(0, 255)), 1'b0, 0);
      end
      rand_ready = 1'b0;
      out_ready  = 1'b1;
      drain();

      // Reset with three results in flight; writes and inputs during reset ignored
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) send(8'($urandom_range(0, 255)), 1'b0, 0);
      rst       = 1'b1;
      lut_we    = 1'b1;
      lut_waddr = 4'd5;
      lut_wdata = 8'd77;
      in_valid  = 1'b1;
      z_value   = 8'h50;
      step();
      rst       = 1'b0;
      lut_we    = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("post_rst_out_valid", int'(out_valid), 0);
      chk("post_rst_in_ready", int'(in_ready), 1);
      step();
      repeat (5) step();
      send(8'h50, 1'b1, 0);
      send(8'h28, 1'b1, 0);
      send(8'hF8, 1'b1, 0);
      drain();
      lut_write(4'd2, 8'd20);
      lut_write(4'd3, 8'd36);
      send(8'h28, 1'b1, 28);
      drain();
      repeat (3) step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
